imem_loader: RTL and testbench

Program loader that writes a program image into the instruction memory before the processor runs. It accepts a byte stream over a valid/ready handshake, parses a 2-byte word-count header, assembles big-endian 32-bit instruction words, and issues one-cycle write strobes at byte addresses BASE_ADR, BASE_ADR+4, … matching the PC's +4 stepping. It holds the processor in reset while loading and verifies a trailing XOR checksum byte.

---
 rtl/imem_loader.sv | 132 +++++++++++++
 tb/tb_imem_loader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Program loader: parses a word-count header from a byte stream, writes big-endian
// 32-bit words into instruction memory at +4 steps and checks a trailing XOR byte.
module imem_loader #(
  parameter logic [31:0] BASE_ADR  = 32'd0,
  parameter int          MAX_WORDS = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_adr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_rst
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HDR_HI = 3'd1;
  localparam logic [2:0] HDR_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] CHK    = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [2:0] ERR    = 3'd6;

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  logic [2:0]  state;
  logic [15:0] cnt;
  logic [15:0] wcnt;
  logic [1:0]  bcnt;
  logic [7:0]  csum;
  logic [23:0] shreg;
  logic        acc;
  logic [15:0] hdr_cnt;

  assign rx_ready = (state == HDR_HI) || (state == HDR_LO) ||
                    (state == DATA)   || (state == CHK);
  assign acc      = rx_valid && rx_ready;
  assign hdr_cnt  = {cnt[15:8], rx_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wcnt    <= '0;
      bcnt    <= '0;
      csum    <= '0;
      shreg   <= '0;
      wr_en   <= 1'b0;
      wr_adr  <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      cpu_rst <= 1'b1;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state   <= HDR_HI;
            cnt     <= '0;
            wcnt    <= '0;
            bcnt    <= '0;
            csum    <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            cpu_rst <= 1'b1;
          end
        end
        HDR_HI: begin
          if (acc) begin
            cnt[15:8] <= rx_data;
            csum      <= csum ^ rx_data;
            state     <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (acc) begin
            cnt  <= hdr_cnt;
            csum <= csum ^ rx_data;
            if (hdr_cnt == 16'd0) begin
              state <= CHK;
            end else if (hdr_cnt > MAX_W) begin
              // oversize image: abort before touching memory, keep the CPU held
              state <= ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (acc) begin
            csum  <= csum ^ rx_data;
            shreg <= {shreg[15:0], rx_data};
            bcnt  <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              wr_en   <= 1'b1;
              wr_adr  <= BASE_ADR + {14'd0, wcnt, 2'b00};
              wr_data <= {shreg, rx_data};
              wcnt    <= wcnt + 16'd1;
              if (wcnt == cnt - 16'd1) state <= CHK;
            end
          end
        end
        CHK: begin
          if (acc) begin
            busy <= 1'b0;
            if (rx_data == csum) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 100) share one byte stream;
// expected writes go into per-instance queues checked by a negedge monitor.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst, start, rx_valid;
  logic [7:0] rx_data;

  logic        rdy0, we0, busy0, done0, err0, crst0;
  logic [31:0] adr0, dat0;
  logic        rdy1, we1, busy1, done1, err1, crst1;
  logic [31:0] adr1, dat1;

  int checks = 0;
  int errors = 0;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [63:0] e0, e1;

  always #5 clk = ~clk;

  imem_loader dut0 (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy0), .wr_en(we0), .wr_adr(adr0), .wr_data(dat0),
    .busy(busy0), .done(done0), .err(err0), .cpu_rst(crst0)
  );

  imem_loader #(.BASE_ADR(32'd100), .MAX_WORDS(50)) dut1 (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rdy1), .wr_en(we1), .wr_adr(adr1), .wr_data(dat1),
    .busy(busy1), .done(done1), .err(err1), .cpu_rst(crst1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // write monitor: every wr_en must match the head of its queue
  always @(negedge clk) begin
    if (we0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0 unexpected write actual adr=%h data=%h required=no write", adr0, dat0);
      end else begin
        e0 = q0.pop_front();
        chk("dut0 wr_adr", adr0, e0[63:32]);
        chk("dut0 wr_data", dat0, e0[31:0]);
      end
    end
    if (we1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1 unexpected write actual adr=%h data=%h required=no write", adr1, dat1);
      end else begin
        e1 = q1.pop_front();
        chk("dut1 wr_adr", adr1, e1[63:32]);
        chk("dut1 wr_data", dat1, e1[31:0]);
      end
    end
  end

  task automatic expect_wr(input int k, input logic [31:0] data);
    q0.push_back({32'(4 * k), data});
    q1.push_back({32'd100 + 32'(4 * k), data});
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    chk("rx_ready on send", {31'd0, rdy0}, 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic status(input string name, input logic d, input logic e,
                        input logic b, input logic c);
    chk({name, " done0"}, {31'd0, done0}, {31'd0, d});
    chk({name, " err0"}, {31'd0, err0}, {31'd0, e});
    chk({name, " busy0"}, {31'd0, busy0}, {31'd0, b});
    chk({name, " cpu_rst0"}, {31'd0, crst0}, {31'd0, c});
    chk({name, " done1"}, {31'd0, done1}, {31'd0, d});
    chk({name, " err1"}, {31'd0, err1}, {31'd0, e});
    chk({name, " cpu_rst1"}, {31'd0, crst1}, {31'd0, c});
  endtask

  task automatic reset_vals(input string name);
    chk({name, " rx_ready"}, {31'd0, rdy0}, 32'd0);
    chk({name, " wr_en"}, {31'd0, we0}, 32'd0);
    chk({name, " wr_adr0"}, adr0, 32'd0);
    chk({name, " wr_data0"}, dat0, 32'd0);
    chk({name, " wr_adr1"}, adr1, 32'd0);
    status(name, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic no_pending(input string name);
    chk({name, " writes outstanding dut0"}, q0.size(), 32'd0);
    chk({name, " writes outstanding dut1"}, q1.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    reset_vals("reset");
    rst = 1'b0;

    // two-word load with good checksum (XOR of all 10 bytes = 41)
    pulse_start();
    status("started", 1'b0, 1'b0, 1'b1, 1'b1);
    expect_wr(0, 32'h20080005);
    expect_wr(1, 32'h8C0903E8);
    send(8'h00); send(8'h02);
    send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    send(8'h8C); send(8'h09); send(8'h03); send(8'hE8);
    send(8'h41);
    status("good load", 1'b1, 1'b0, 1'b0, 1'b0);
    no_pending("good load");

    // same stream, wrong checksum
    pulse_start();
    expect_wr(0, 32'h20080005);
    expect_wr(1, 32'h8C0903E8);
    send(8'h00); send(8'h02);
    send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    send(8'h8C); send(8'h09); send(8'h03); send(8'hE8);
    send(8'h42);
    status("bad checksum", 1'b0, 1'b1, 1'b0, 1'b1);
    no_pending("bad checksum");

    // oversize header 0x0033 = 51
    pulse_start();
    send(8'h00); send(8'h33);
    status("oversize", 1'b0, 1'b1, 1'b0, 1'b1);
    chk("oversize rx_ready", {31'd0, rdy0}, 32'd0);
    idle(3);
    chk("oversize stays in err", {31'd0, err0}, 32'd1);

    // empty image
    pulse_start();
    send(8'h00); send(8'h00); send(8'h00);
    status("empty", 1'b1, 1'b0, 1'b0, 1'b0);

    // partial one-word load with bubbles, aborted by rst after byte 3
    pulse_start();
    send(8'h00); idle(2); send(8'h01); idle(2); send(8'hAA);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    reset_vals("rst mid-load");
    rst = 1'b0;
    idle(2);
    chk("post-rst wr_en", {31'd0, we0}, 32'd0);

    // full one-word load with bubbles, checksum 09
    pulse_start();
    expect_wr(0, 32'h12345678);
    send(8'h00); idle(2); send(8'h01); idle(2);
    send(8'h12); idle(2); send(8'h34); idle(2);
    send(8'h56); idle(2); send(8'h78); idle(2);
    chk("bubble busy", {31'd0, busy0}, 32'd1);
    send(8'h09);
    status("bubbled load", 1'b1, 1'b0, 1'b0, 1'b0);
    no_pending("bubbled load");

    // three words, start pulsed mid-load, checksum CF
    pulse_start();
    expect_wr(0, 32'h11223344);
    expect_wr(1, 32'h55667788);
    expect_wr(2, 32'h99AABBCC);
    send(8'h00); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    pulse_start();
    status("start mid-load", 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h55); send(8'h66); send(8'h77); send(8'h88);
    send(8'h99); send(8'hAA); send(8'hBB); send(8'hCC);
    send(8'hCF);
    status("three words", 1'b1, 1'b0, 1'b0, 1'b0);
    no_pending("three words");
    chk("dut1 last wr_adr", adr1, 32'd108);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
